// File: rtl/dcache_fill_ctrl.sv
// Data-cache miss handler: MSHR table, BUS_LOAD issue, tagged response matching and cache fill.
// Build option DCACHE_FILL_BYPASS_EN adds byp_valid/byp_addr/byp_data early-wakeup outputs.
module dcache_fill_ctrl #(
  parameter int NUM_MSHR = 4,
  parameter int IDX_W    = 5,
  parameter int TAG_W    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             miss_valid,
  input  logic [63:0]      miss_addr,
  output logic             miss_ready,
  input  logic             mem_grant,
  output logic [1:0]       mem_cmd,
  output logic [63:0]      mem_addr,
  input  logic [3:0]       mem_response,
  input  logic [3:0]       mem_tag,
  input  logic [63:0]      mem_data,
  output logic             fill_en,
  output logic [IDX_W-1:0] fill_idx,
  output logic [TAG_W-1:0] fill_tag,
  output logic [63:0]      fill_data,
`ifdef DCACHE_FILL_BYPASS_EN
  output logic             byp_valid,
  output logic [63:0]      byp_addr,
  output logic [63:0]      byp_data,
`endif
  output logic             mshr_full
);

  localparam int IW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_LOAD = 2'b01;

  typedef enum logic [1:0] {
    ENT_FREE       = 2'd0,
    ENT_WAIT_ISSUE = 2'd1,
    ENT_WAIT_DATA  = 2'd2
  } ent_state_e;

  ent_state_e       st_q   [NUM_MSHR];
  ent_state_e       st_d   [NUM_MSHR];
  logic [60:0]      blk_q  [NUM_MSHR];
  logic [60:0]      blk_d  [NUM_MSHR];
  logic [3:0]       ttag_q [NUM_MSHR];
  logic [3:0]       ttag_d [NUM_MSHR];

  logic             fill_en_q, fill_en_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
  logic [63:0]      fill_data_q, fill_data_d;
  logic [60:0]      fill_blk_q, fill_blk_d;
  logic             mshr_full_q, mshr_full_d;

  logic [60:0]      miss_blk;
  logic [2:0]       miss_lo_unused;
  logic             merge_hit, free_found, iss_found, rsp_found;
  logic             do_alloc, do_issue;
  logic [IW-1:0]    alloc_idx, iss_idx, rsp_idx;

  assign miss_blk       = miss_addr[63:3];
  assign miss_lo_unused = miss_addr[2:0];

  // Table scan: merge detection, lowest FREE slot, lowest WAIT_ISSUE slot, tag match.
  always_comb begin
    merge_hit  = fill_en_q && (fill_blk_q == miss_blk);
    free_found = 1'b0;
    alloc_idx  = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    rsp_found  = 1'b0;
    rsp_idx    = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if ((st_q[i] != ENT_FREE) && (blk_q[i] == miss_blk)) merge_hit = 1'b1;
      if (!free_found && (st_q[i] == ENT_FREE)) begin
        free_found = 1'b1;
        alloc_idx  = IW'(i);
      end
      if (!iss_found && (st_q[i] == ENT_WAIT_ISSUE)) begin
        iss_found = 1'b1;
        iss_idx   = IW'(i);
      end
      if (!rsp_found && (mem_tag != 4'd0) && (st_q[i] == ENT_WAIT_DATA) &&
          (ttag_q[i] == mem_tag)) begin
        rsp_found = 1'b1;
        rsp_idx   = IW'(i);
      end
    end
  end

  // Miss handshake: a miss is taken (allocated or merged) in any cycle with
  // miss_valid && miss_ready; miss_ready never depends on miss_valid.
  assign miss_ready = merge_hit | free_found;
  assign do_alloc   = miss_valid & ~merge_hit & free_found;
  assign mem_cmd    = iss_found ? BUS_LOAD : BUS_NONE;
  assign mem_addr   = iss_found ? {blk_q[iss_idx], 3'b000} : 64'd0;
  assign do_issue   = iss_found & mem_grant & (mem_response != 4'd0);

  // Issue, response and allocation always touch three different entries.
  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      st_d[i]   = st_q[i];
      blk_d[i]  = blk_q[i];
      ttag_d[i] = ttag_q[i];
    end
    fill_en_d   = rsp_found;
    fill_idx_d  = fill_idx_q;
    fill_tag_d  = fill_tag_q;
    fill_data_d = fill_data_q;
    fill_blk_d  = fill_blk_q;
    if (do_issue) begin
      st_d[iss_idx]   = ENT_WAIT_DATA;
      ttag_d[iss_idx] = mem_response;
    end
    if (rsp_found) begin
      st_d[rsp_idx] = ENT_FREE;
      fill_idx_d    = blk_q[rsp_idx][IDX_W-1:0];
      fill_tag_d    = blk_q[rsp_idx][TAG_W+IDX_W-1:IDX_W];
      fill_data_d   = mem_data;
      fill_blk_d    = blk_q[rsp_idx];
    end
    if (do_alloc) begin
      st_d[alloc_idx]  = ENT_WAIT_ISSUE;
      blk_d[alloc_idx] = miss_blk;
    end
    mshr_full_d = 1'b1;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (st_d[i] == ENT_FREE) mshr_full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        st_q[i]   <= ENT_FREE;
        blk_q[i]  <= '0;
        ttag_q[i] <= '0;
      end
      fill_en_q   <= 1'b0;
      fill_idx_q  <= '0;
      fill_tag_q  <= '0;
      fill_data_q <= '0;
      fill_blk_q  <= '0;
      mshr_full_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        st_q[i]   <= st_d[i];
        blk_q[i]  <= blk_d[i];
        ttag_q[i] <= ttag_d[i];
      end
      fill_en_q   <= fill_en_d;
      fill_idx_q  <= fill_idx_d;
      fill_tag_q  <= fill_tag_d;
      fill_data_q <= fill_data_d;
      fill_blk_q  <= fill_blk_d;
      mshr_full_q <= mshr_full_d;
    end
  end

  assign fill_en   = fill_en_q;
  assign fill_idx  = fill_idx_q;
  assign fill_tag  = fill_tag_q;
  assign fill_data = fill_data_q;
  assign mshr_full = mshr_full_q;

`ifdef DCACHE_FILL_BYPASS_EN
  assign byp_valid = rsp_found;
  assign byp_addr  = rsp_found ? {blk_q[rsp_idx], 3'b000} : 64'd0;
  assign byp_data  = mem_data;
`endif

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Bench for dcache_fill_ctrl: directed scenarios plus a randomized run against an MSHR table model.
`timescale 1ns/1ps
module tb_dcache_fill_ctrl;
  localparam int NUM_MSHR = 4;
  localparam int IDX_W    = 5;
  localparam int TAG_W    = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             miss_valid = 1'b0;
  logic [63:0]      miss_addr = '0;
  logic             miss_ready;
  logic             mem_grant = 1'b0;
  logic [1:0]       mem_cmd;
  logic [63:0]      mem_addr;
  logic [3:0]       mem_response = '0;
  logic [3:0]       mem_tag = '0;
  logic [63:0]      mem_data = '0;
  logic             fill_en;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [63:0]      fill_data;
  logic             mshr_full;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  // Reference model: each slot is a miss in flight (busy), possibly already sent (issued).
  bit          m_busy [NUM_MSHR];
  bit          m_iss  [NUM_MSHR];
  logic [60:0] m_blk  [NUM_MSHR];
  logic [3:0]  m_tag  [NUM_MSHR];
  bit          e_fill_en;
  logic [60:0] e_fill_blk;
  bit          e_full;

  always #5 clock = ~clock;

  dcache_fill_ctrl #(.NUM_MSHR(NUM_MSHR), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .mem_grant(mem_grant), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_response(mem_response), .mem_tag(mem_tag), .mem_data(mem_data),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
    .mshr_full(mshr_full)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    miss_valid = 1'b0; miss_addr = '0; mem_grant = 1'b0;
    mem_response = '0; mem_tag = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL reset_fill_en got %0h exp 0", fill_en); end
    n_tests++; if (fill_idx !== 5'd0) begin n_fail++; $display("FAIL reset_fill_idx got %0h exp 0", fill_idx); end
    n_tests++; if (fill_tag !== 10'd0) begin n_fail++; $display("FAIL reset_fill_tag got %0h exp 0", fill_tag); end
    n_tests++; if (fill_data !== 64'd0) begin n_fail++; $display("FAIL reset_fill_data got %0h exp 0", fill_data); end
    n_tests++; if (mem_cmd !== 2'b00) begin n_fail++; $display("FAIL reset_mem_cmd got %0h exp 0", mem_cmd); end
    n_tests++; if (mem_addr !== 64'd0) begin n_fail++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
    n_tests++; if (mshr_full !== 1'b0) begin n_fail++; $display("FAIL reset_mshr_full got %0h exp 0", mshr_full); end
    n_tests++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_miss_ready got %0h exp 1", miss_ready); end
  endtask

  task automatic test_single_miss();
    miss_valid = 1'b1; miss_addr = 64'h1238; #1;
    n_tests++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %0h exp 1", miss_ready); end
    n_tests++; if (mem_cmd !== 2'b00) begin n_fail++; $display("FAIL single_no_early_issue got %0h exp 0", mem_cmd); end
    tick();
    miss_valid = 1'b0; mem_grant = 1'b1; mem_response = 4'd3; #1;
    n_tests++; if (mem_cmd !== 2'b01) begin n_fail++; $display("FAIL single_cmd got %0h exp 1", mem_cmd); end
    n_tests++; if (mem_addr !== 64'h1238) begin n_fail++; $display("FAIL single_addr got %0h exp 1238", mem_addr); end
    tick();
    mem_grant = 1'b0; mem_response = '0; #1;
    n_tests++; if (mem_cmd !== 2'b00) begin n_fail++; $display("FAIL single_cmd_after got %0h exp 0", mem_cmd); end
    tick();
    mem_tag = 4'd3; mem_data = 64'hDEAD_BEEF; #1;
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL single_fill_latency got %0h exp 0", fill_en); end
    tick();
    mem_tag = '0;
    n_tests++; if (fill_en !== 1'b1) begin n_fail++; $display("FAIL single_fill_en got %0h exp 1", fill_en); end
    n_tests++; if (fill_idx !== 5'd7) begin n_fail++; $display("FAIL single_fill_idx got %0h exp 7", fill_idx); end
    n_tests++; if (fill_tag !== 10'h012) begin n_fail++; $display("FAIL single_fill_tag got %0h exp 12", fill_tag); end
    n_tests++; if (fill_data !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL single_fill_data got %0h exp deadbeef", fill_data); end
    tick();
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL single_fill_pulse got %0h exp 0", fill_en); end
    n_tests++; if (mshr_full !== 1'b0) begin n_fail++; $display("FAIL single_full got %0h exp 0", mshr_full); end
  endtask

  task automatic test_merge();
    miss_valid = 1'b1; miss_addr = 64'h1238;
    tick();
    miss_addr = 64'h123C; #1;
    n_tests++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL merge_ready got %0h exp 1", miss_ready); end
    tick();
    miss_valid = 1'b0; mem_grant = 1'b1; mem_response = 4'd6; #1;
    n_tests++; if (mem_addr !== 64'h1238) begin n_fail++; $display("FAIL merge_addr got %0h exp 1238", mem_addr); end
    tick();
    mem_response = 4'd7; #1;
    n_tests++; if (mem_cmd !== 2'b00) begin n_fail++; $display("FAIL merge_single_request got %0h exp 0", mem_cmd); end
    mem_grant = 1'b0; mem_response = '0; mem_tag = 4'd6; mem_data = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_tag = '0;
    n_tests++; if (fill_en !== 1'b1) begin n_fail++; $display("FAIL merge_fill_en got %0h exp 1", fill_en); end
    n_tests++; if (fill_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL merge_fill_data got %0h exp 123456789abcdef", fill_data); end
    tick();
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL merge_one_fill got %0h exp 0", fill_en); end
  endtask

  task automatic test_full();
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      miss_valid = 1'b1; miss_addr = 64'(i + 1) << 12; #1;
      n_tests++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL full_alloc_ready got %0h exp 1", miss_ready); end
      tick();
    end
    miss_addr = 64'h5000; #1;
    n_tests++; if (mshr_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %0h exp 1", mshr_full); end
    n_tests++; if (miss_ready !== 1'b0) begin n_fail++; $display("FAIL full_fifth_ready got %0h exp 0", miss_ready); end
    miss_valid = 1'b0; mem_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_response = 4'(i + 1); #1;
      n_tests++; if (mem_addr !== (64'(i + 1) << 12)) begin n_fail++; $display("FAIL full_issue_addr got %0h exp %0h", mem_addr, 64'(i + 1) << 12); end
      tick();
    end
    mem_grant = 1'b0; mem_response = '0; #1;
    n_tests++; if (mem_cmd !== 2'b00) begin n_fail++; $display("FAIL full_all_issued got %0h exp 0", mem_cmd); end
    for (int k = 0; k < 4; k++) begin
      mem_tag = 4'(4 - k); mem_data = 64'hF000 + 64'(k);
      tick();
      mem_tag = '0;
      n_tests++; if (fill_en !== 1'b1) begin n_fail++; $display("FAIL full_fill_en got %0h exp 1", fill_en); end
      n_tests++; if (fill_tag !== 10'((4 - k) << 4)) begin n_fail++; $display("FAIL full_fill_tag got %0h exp %0h", fill_tag, 10'((4 - k) << 4)); end
      n_tests++; if (fill_data !== 64'hF000 + 64'(k)) begin n_fail++; $display("FAIL full_fill_data got %0h exp %0h", fill_data, 64'hF000 + 64'(k)); end
      if (k == 0) begin
        n_tests++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_fill got %0h exp 1", miss_ready); end
        n_tests++; if (mshr_full !== 1'b0) begin n_fail++; $display("FAIL full_flag_after_fill got %0h exp 0", mshr_full); end
      end
    end
    tick();
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL full_fill_end got %0h exp 0", fill_en); end
  endtask

  task automatic test_retry();
    miss_valid = 1'b1; miss_addr = 64'h2000;
    tick();
    miss_valid = 1'b0; mem_grant = 1'b1; mem_response = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (mem_cmd !== 2'b01 || mem_addr !== 64'h2000) begin n_fail++; $display("FAIL retry_hold got cmd %0h addr %0h exp 1 2000", mem_cmd, mem_addr); end
      tick();
    end
    mem_response = 4'd5; #1;
    n_tests++; if (mem_cmd !== 2'b01 || mem_addr !== 64'h2000) begin n_fail++; $display("FAIL retry_accept got cmd %0h addr %0h exp 1 2000", mem_cmd, mem_addr); end
    tick();
    mem_grant = 1'b0; mem_response = '0; #1;
    n_tests++; if (mem_cmd !== 2'b00) begin n_fail++; $display("FAIL retry_done got %0h exp 0", mem_cmd); end
    mem_tag = 4'd5; mem_data = 64'h5555;
    tick();
    mem_tag = '0;
    n_tests++; if (fill_en !== 1'b1 || fill_data !== 64'h5555) begin n_fail++; $display("FAIL retry_fill got en %0h data %0h exp 1 5555", fill_en, fill_data); end
    n_tests++; if (fill_tag !== 10'h020) begin n_fail++; $display("FAIL retry_fill_tag got %0h exp 20", fill_tag); end
    tick();
  endtask

  task automatic test_unknown_tag();
    mem_tag = 4'd9; mem_data = 64'h9999;
    tick();
    mem_tag = '0;
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL unknown_tag_empty got %0h exp 0", fill_en); end
    miss_valid = 1'b1; miss_addr = 64'h3000;
    tick();
    miss_valid = 1'b0; mem_grant = 1'b1; mem_response = 4'd2;
    tick();
    mem_grant = 1'b0; mem_response = '0; mem_tag = 4'd9;
    tick();
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL unknown_tag_pending got %0h exp 0", fill_en); end
    mem_tag = 4'd2; mem_data = 64'h2222;
    tick();
    mem_tag = '0;
    n_tests++; if (fill_en !== 1'b1 || fill_data !== 64'h2222) begin n_fail++; $display("FAIL unknown_then_known got en %0h data %0h exp 1 2222", fill_en, fill_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      miss_valid = 1'b1; miss_addr = 64'(i + 1) << 12;
      tick();
    end
    miss_valid = 1'b0; mem_grant = 1'b1; mem_response = 4'd7;
    tick();
    mem_response = 4'd8;
    tick();
    mem_grant = 1'b0; mem_response = '0; #1;
    n_tests++; if (mem_cmd !== 2'b01 || mshr_full !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got cmd %0h full %0h exp 1 1", mem_cmd, mshr_full); end
    #2;
    reset = 1'b1; #1;
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL midrst_fill_en got %0h exp 0", fill_en); end
    n_tests++; if (mem_cmd !== 2'b00) begin n_fail++; $display("FAIL midrst_mem_cmd got %0h exp 0", mem_cmd); end
    n_tests++; if (mshr_full !== 1'b0) begin n_fail++; $display("FAIL midrst_full got %0h exp 0", mshr_full); end
    tick();
    reset = 1'b0;
    mem_tag = 4'd7; mem_data = 64'h7777;
    tick();
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL midrst_old_tag7 got %0h exp 0", fill_en); end
    mem_tag = 4'd8;
    tick();
    mem_tag = '0;
    n_tests++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL midrst_old_tag8 got %0h exp 0", fill_en); end
  endtask

  function automatic bit tag_in_use(input logic [3:0] t);
    for (int j = 0; j < NUM_MSHR; j++)
      if (m_busy[j] && m_iss[j] && m_tag[j] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_fill_outputs();
    logic [63:0] exp_data;
    n_tests++; if (fill_en !== e_fill_en) begin n_fail++; $display("FAIL rnd_fill_en got %0h exp %0h", fill_en, e_fill_en); end
    if (fill_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rnd_fill_unexpected got data %0h exp no fill", fill_data);
      end else begin
        exp_data = exp_q.pop_front();
        if (fill_data !== exp_data) begin n_fail++; $display("FAIL rnd_fill_data got %0h exp %0h", fill_data, exp_data); end
      end
      n_tests++; if ({fill_tag, fill_idx} !== e_fill_blk[TAG_W+IDX_W-1:0]) begin n_fail++; $display("FAIL rnd_fill_line got %0h exp %0h", {fill_tag, fill_idx}, e_fill_blk[TAG_W+IDX_W-1:0]); end
    end
  endtask

  task automatic test_random();
    int fr_i, is_i, rs_i, sel;
    bit merge;
    logic [3:0] t;
    logic [60:0] blk;
    int cand[$];
    do_reset();
    for (int j = 0; j < NUM_MSHR; j++) begin
      m_busy[j] = 0; m_iss[j] = 0; m_blk[j] = '0; m_tag[j] = '0;
    end
    e_fill_en = 0; e_fill_blk = '0; e_full = 0;
    exp_q.delete();
    for (int c = 0; c < 800; c++) begin
      check_fill_outputs();
      n_tests++; if (mshr_full !== e_full) begin n_fail++; $display("FAIL rnd_full got %0h exp %0h", mshr_full, e_full); end
      miss_valid = ($urandom_range(0, 1) == 1);
      blk = 61'h240 + 61'($urandom_range(0, 5));
      miss_addr = {blk, 3'($urandom_range(0, 7))};
      mem_grant = ($urandom_range(0, 3) != 0);
      mem_data = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      mem_tag = '0;
      cand.delete();
      for (int j = 0; j < NUM_MSHR; j++) if (m_busy[j] && m_iss[j]) cand.push_back(j);
      if (sel < 5 && cand.size() > 0) begin
        mem_tag = m_tag[cand[$urandom_range(0, cand.size() - 1)]];
      end else if (sel < 7) begin
        do t = 4'($urandom_range(1, 15)); while (tag_in_use(t));
        mem_tag = t;
      end
      if ($urandom_range(0, 3) == 0) mem_response = '0;
      else if (mem_tag != 0 && $urandom_range(0, 2) == 0) mem_response = mem_tag;
      else begin
        do t = 4'($urandom_range(1, 15)); while (tag_in_use(t) && t != mem_tag);
        mem_response = t;
      end
      #1;
      merge = e_fill_en && (e_fill_blk == miss_addr[63:3]);
      fr_i = -1; is_i = -1; rs_i = -1;
      for (int j = 0; j < NUM_MSHR; j++) begin
        if (m_busy[j] && m_blk[j] == miss_addr[63:3]) merge = 1;
        if (!m_busy[j] && fr_i < 0) fr_i = j;
        if (m_busy[j] && !m_iss[j] && is_i < 0) is_i = j;
        if (m_busy[j] && m_iss[j] && mem_tag != 0 && m_tag[j] == mem_tag) rs_i = j;
      end
      n_tests++; if (miss_ready !== (merge || fr_i >= 0)) begin n_fail++; $display("FAIL rnd_ready got %0h exp %0h", miss_ready, (merge || fr_i >= 0)); end
      n_tests++; if (mem_cmd !== ((is_i >= 0) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL rnd_cmd got %0h exp %0h", mem_cmd, (is_i >= 0)); end
      if (is_i >= 0) begin
        n_tests++; if (mem_addr !== {m_blk[is_i], 3'b000}) begin n_fail++; $display("FAIL rnd_addr got %0h exp %0h", mem_addr, {m_blk[is_i], 3'b000}); end
      end
      if (is_i >= 0 && mem_grant && mem_response != 0) begin
        m_iss[is_i] = 1; m_tag[is_i] = mem_response;
      end
      e_fill_en = (rs_i >= 0);
      if (rs_i >= 0) begin
        m_busy[rs_i] = 0; e_fill_blk = m_blk[rs_i]; exp_q.push_back(mem_data);
      end
      if (miss_valid && !merge && fr_i >= 0) begin
        m_busy[fr_i] = 1; m_iss[fr_i] = 0; m_blk[fr_i] = miss_addr[63:3];
      end
      e_full = 1;
      for (int j = 0; j < NUM_MSHR; j++) if (!m_busy[j]) e_full = 0;
      tick();
    end
    idle_inputs();
    check_fill_outputs();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_fills_missing got %0d left exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_merge();
    test_full();
    test_retry();
    test_unknown_tag();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_fill_ctrl.md
Name: dcache_fill_ctrl

Overview:
- Miss handler for the direct-mapped data cache.
- Accepts load-miss block addresses, tracks them in a small MSHR table and issues BUS_LOAD requests on the shared memory port.
- Matches tagged memory responses back to MSHR entries and drives the cache fill port (ld_en/ld_idx/ld_tag/ld_data side) with the returned block.
- Sits between the LSQ miss path and the memory arbiter.

Parameters:
- NUM_MSHR, 4, number of outstanding-miss entries (power of 2, 2..8).
- IDX_W, 5, cache index width; index = miss_addr[IDX_W+2:3].
- TAG_W, 10, cache tag width; tag = miss_addr[TAG_W+IDX_W+2:IDX_W+3].

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- miss_valid  in  1  miss request present.
- miss_addr  in  64  miss byte address; bits [2:0] ignored.
- miss_ready  out  1  request accepted this cycle when miss_valid is also high.
- mem_grant  in  1  arbiter grants memory port this cycle.
- mem_cmd  out  2  2'b00 BUS_NONE, 2'b01 BUS_LOAD.
- mem_addr  out  64  request address, 8-byte aligned.
- mem_response  in  4  nonzero means the request is accepted, with this transaction tag; 0 means rejected.
- mem_tag  in  4  nonzero means a data return for this transaction tag.
- mem_data  in  64  returned block.
- fill_en  out  1  write cache line.
- fill_idx  out  IDX_W  line index.
- fill_tag  out  TAG_W  line tag.
- fill_data  out  64  line data.
- mshr_full  out  1  all entries non-FREE.

Behaviour:
- Reset is async and active-high, applied to every state register.
- Reset values:
  - all entries FREE;
  - fill_en=0, fill_idx=0, fill_tag=0, fill_data=0;
  - mem_cmd=BUS_NONE, mem_addr=0;
  - mshr_full=0.
- Each entry holds a state, block address [63:3] and 4-bit mem transaction tag. Per-entry FSM:
  - FREE -> WAIT_ISSUE on allocation.
  - WAIT_ISSUE -> WAIT_DATA when issued and mem_response!=0; mem_response is stored as the entry's transaction tag.
  - WAIT_DATA -> FREE on a mem_tag match.
- Accept/merge:
  - miss_ready is combinational.
  - If the block address matches any non-FREE entry, or matches the currently asserted fill line, then miss_ready=1 and the request merges: no allocation, no new request.
  - Otherwise miss_ready=1 iff an entry is FREE at the start of the cycle; the lowest FREE index is allocated.
  - An entry freed this cycle is not reusable until the next cycle.
- Issue:
  - The lowest-index WAIT_ISSUE entry drives mem_cmd=BUS_LOAD and mem_addr combinationally, regardless of mem_grant.
  - A request counts as issued only when mem_grant=1 and mem_response!=0.
  - If mem_grant=0 or mem_response=0, the entry stays WAIT_ISSUE and retries next cycle.
  - At most one issue per cycle. A newly allocated entry can issue no earlier than the cycle after acceptance.
- Response:
  - mem_tag!=0 matching a WAIT_DATA entry causes, at the next edge: fill_en=1, fill_idx and fill_tag from that entry's address, fill_data=mem_data, and the entry goes FREE.
  - fill_en is a single-cycle pulse.
  - mem_tag matching no entry is ignored (no fill). mem_tag=0 means no fill.
- Fill latency: 1 cycle from the mem_tag cycle.
- Simultaneous events: issue, response and acceptance in the same cycle are independent and all take effect.
  - If the issuing entry's new mem_response equals the mem_tag arriving that cycle, the response does not match that entry.
- Duplicate transaction tags among WAIT_DATA entries are illegal (memory guarantees uniqueness).
- mshr_full is registered and reflects entry state after the edge.
- Reset mid-operation: all entries are dropped and in-flight responses after reset are ignored.

Optional Feature:
- Macro: DCACHE_FILL_BYPASS_EN.
- Defined: adds output ports byp_valid (1), byp_addr (64) and byp_data (64). In the mem_tag-match cycle these are driven combinationally with the entry block address (bits [2:0]=0) and mem_data, so dependent loads can wake one cycle early.
- Not defined: the ports do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then miss_addr=0x1238, mem_grant=1, mem_response=3; mem_tag=3 with mem_data=0xDEAD_BEEF two cycles later -> mem_cmd=BUS_LOAD with mem_addr=0x1238, next cycle fill_en=1, fill_idx=7, fill_tag=0x12, fill_data=0xDEADBEEF, then the entry is FREE.
- Two misses to 0x1238 and 0x123C -> second merges: exactly one BUS_LOAD issued, one fill.
- Four distinct misses with mem_grant=0 -> mshr_full=1; fifth miss gets miss_ready=0. Grant and return tags 4,3,2,1 -> fills in tag-return order, and miss_ready=1 again after the first fill.
- mem_response=0 for 3 cycles on 0x2000 -> mem_cmd held at BUS_LOAD with mem_addr=0x2000 until response 5 is accepted; exactly one entry is in WAIT_DATA.
- Unknown mem_tag=9 with no entry in WAIT_DATA -> fill_en stays 0.
- Async reset asserted mid-clock with 2 entries outstanding -> immediately fill_en=0, mem_cmd=BUS_NONE, mshr_full=0; a later mem_tag for an old tag produces no fill.
